axi_rd_slave: RTL and testbench
===============================

AXI_RD_SLAVE -- requirements
Module: axi_rd_slave

Interface
REQ-001 Parameter AWID_WIDTH, default from axi_pkg, width of ARID/RID.
REQ-002 Parameter AWADDR_WIDTH, default from axi_pkg, byte-address width.
REQ-003 Parameter WDATA_WIDTH, default from axi_pkg, RDATA width in bits (power of two, >=32).
REQ-004 Parameter MEM_DEPTH, default 256, number of WDATA_WIDTH-bit words.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 ARID/ARADDR/ARLEN[7:0]/ARSIZE[2:0]/ARBURST[1:0]/ARREGION[3:0]/ARVALID  in  AR channel from master; ARREGION ignored.
REQ-008 ARREADY  out  1  AR accept.
REQ-009 RID/RDATA/RRESP[1:0]/RLAST/RVALID  out  R channel to master.
REQ-010 RREADY  in  1  R accept.
REQ-011 mem_we  in  1; mem_waddr  in  $clog2(MEM_DEPTH); mem_wdata  in  WDATA_WIDTH -- backdoor word write for preload.

Function
REQ-012 FSM states IDLE, BURST; IDLE->BURST on AR handshake; BURST->IDLE on R handshake with RLAST=1 and no queued request.
REQ-013 AR handshake = ARVALID&ARREADY at a rising edge; command fields captured that edge.
REQ-014 First RVALID asserts the cycle after AR handshake (latency 1); beats are back-to-back while RREADY=1.
REQ-015 RVALID once high SHALL stay high with RID/RDATA/RRESP/RLAST stable until RREADY=1.
REQ-016 Burst length = ARLEN+1 beats; RLAST=1 only on final beat; 8-bit beat counter, ARLEN=255 gives 256 beats.
REQ-017 RID of every beat = captured ARID.
REQ-018 Word index = byte address >> log2(WDATA_WIDTH/8); INCR adds (1<<ARSIZE) bytes per beat; FIXED keeps address constant.
REQ-019 ARBURST=WRAP(2'b10) or reserved(2'b11): all beats RRESP=SLVERR(2'b10), RDATA=0, beat count still honoured.
REQ-020 ARSIZE larger than log2(WDATA_WIDTH/8): all beats SLVERR, RDATA=0.
REQ-021 Beat whose word index >= MEM_DEPTH: RRESP=DECERR(2'b11), RDATA=0; other beats of same burst unaffected.
REQ-022 Otherwise RRESP=OKAY, RDATA=memory word (full word; narrow beats do not lane-shift).
REQ-023 Backdoor write same cycle as read of same word: R beat presented next cycle returns new data.
REQ-024 Address arithmetic wraps modulo 2^AWADDR_WIDTH; no 4KB-boundary check.

Reset
REQ-025 rst=1 immediately forces: state IDLE, ARREADY=0, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0, counters 0, AR queue empty; memory contents not reset.
REQ-026 rst asserted mid-burst abandons the burst; no further beats after release.
REQ-027 ARREADY rises the first clk edge after rst deasserts.

Configuration
REQ-028 Macro AXI_RD_SLV_AR_QUEUE_EN defined: 2-entry AR queue; ARREADY=1 while queue not full, also during BURST; next burst's first beat follows previous RLAST handshake with zero idle cycles.
REQ-029 Macro undefined: ARREADY=1 only in IDLE; one cycle of ARREADY=1 in IDLE between bursts; one outstanding burst.

Structure
REQ-030 axi_pkg holds AWID_WIDTH, AWADDR_WIDTH, WDATA_WIDTH, RRESP encodings (OKAY/EXOKAY/SLVERR/DECERR), ARBURST encodings and ar_cmd_t struct (id, addr, len, size, burst).
REQ-031 Sub-module axi_rd_ar_fifo (2-deep ar_cmd_t FIFO, full/empty flags) instantiated only under AXI_RD_SLV_AR_QUEUE_EN.
REQ-032 Memory is a flat register array, single read port, backdoor write port.

Verification
REQ-033 Preload words 0..3 = 0xA0..0xA3; AR id=5 addr=0x0 len=3 INCR full size, RREADY=1 -> 4 consecutive beats A0..A3, RID=5, OKAY, RLAST on 4th, first beat 1 cycle after AR.
REQ-034 Same burst with RREADY toggling 1/0 -> each beat held stable while RREADY=0, no beat lost or duplicated.
REQ-035 FIXED len=2 at word 2 -> three beats all 0xA2; WRAP len=1 -> two beats SLVERR, RDATA=0, RLAST on 2nd.
REQ-036 INCR len=1 starting at word MEM_DEPTH-1 -> beat 0 OKAY, beat 1 DECERR RDATA=0.
REQ-037 rst pulse during beat 2 of len=7 burst -> RVALID=0 same cycle; after release, new AR id=1 len=0 -> single OKAY beat RID=1.
REQ-038 With AXI_RD_SLV_AR_QUEUE_EN: two ARs back-to-back (id 1 len 1, id 2 len 0) -> 3 contiguous beats, RLAST on beats 2 and 3; without macro -> second ARREADY only after first RLAST handshake.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-slave definitions: default widths, response/burst encodings,
// captured AR command payload and read FSM state encoding.
package axi_pkg;

   localparam int unsigned AWID_WIDTH   = 4;
   localparam int unsigned AWADDR_WIDTH = 32;
   localparam int unsigned WDATA_WIDTH  = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   typedef struct packed {
      logic [AWID_WIDTH-1:0]   id;
      logic [AWADDR_WIDTH-1:0] addr;
      logic [7:0]              len;
      logic [2:0]              size;
      logic [1:0]              burst;
   } ar_cmd_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } rd_state_e;

endpackage

// File: rtl/axi_rd_ar_fifo.sv
// Two-entry AR command queue with registered full/empty flags; head is a
// mux of the storage registers.
module axi_rd_ar_fifo
   import axi_pkg::*;
#(
   parameter type cmd_t = ar_cmd_t
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  cmd_t din,
   output cmd_t head_c,
   output logic full,
   output logic empty
);

   cmd_t       ent_q [2];
   cmd_t       ent_d [2];
   logic       wptr_q, wptr_d;
   logic       rptr_q, rptr_d;
   logic [1:0] cnt_q, cnt_d;
   logic       full_q, full_d;
   logic       empty_q, empty_d;
   logic       push_ok, pop_ok;

   assign push_ok = push & ~full_q;
   assign pop_ok  = pop & ~empty_q;

   always_comb begin
      ent_d  = ent_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_ok) begin
         ent_d[wptr_q] = din;
         wptr_d        = ~wptr_q;
      end
      if (pop_ok) begin
         rptr_d = ~rptr_q;
      end
      cnt_d   = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
      full_d  = (cnt_d == 2'd2);
      empty_d = (cnt_d == 2'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_q[0] <= '0;
         ent_q[1] <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         cnt_q    <= 2'd0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         ent_q   <= ent_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   assign head_c = ent_q[rptr_q];
   assign full   = full_q;
   assign empty  = empty_q;

endmodule

// File: rtl/axi_rd_slave.sv
// AXI4 read-only slave over a flat word memory with a backdoor preload port.
// Define AXI_RD_SLV_AR_QUEUE_EN to add a 2-deep AR queue for gapless bursts.
module axi_rd_slave
   import axi_pkg::*;
#(
   parameter int unsigned AWID_WIDTH   = axi_pkg::AWID_WIDTH,
   parameter int unsigned AWADDR_WIDTH = axi_pkg::AWADDR_WIDTH,
   parameter int unsigned WDATA_WIDTH  = axi_pkg::WDATA_WIDTH,
   parameter int unsigned MEM_DEPTH    = 256
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [AWID_WIDTH-1:0]         ARID,
   input  logic [AWADDR_WIDTH-1:0]       ARADDR,
   input  logic [7:0]                    ARLEN,
   input  logic [2:0]                    ARSIZE,
   input  logic [1:0]                    ARBURST,
   input  logic [3:0]                    ARREGION,
   input  logic                          ARVALID,
   output logic                          ARREADY,
   output logic [AWID_WIDTH-1:0]         RID,
   output logic [WDATA_WIDTH-1:0]        RDATA,
   output logic [1:0]                    RRESP,
   output logic                          RLAST,
   output logic                          RVALID,
   input  logic                          RREADY,
   input  logic                          mem_we,
   input  logic [$clog2(MEM_DEPTH)-1:0]  mem_waddr,
   input  logic [WDATA_WIDTH-1:0]        mem_wdata
);

   localparam int unsigned BYTE_SHIFT = $clog2(WDATA_WIDTH / 8);
   localparam int unsigned MIDX_W     = $clog2(MEM_DEPTH);

   typedef struct packed {
      logic [AWID_WIDTH-1:0]   id;
      logic [AWADDR_WIDTH-1:0] addr;
      logic [7:0]              len;
      logic [2:0]              size;
      logic [1:0]              burst;
   } cmd_t;

   logic [WDATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   rd_state_e               state_q, state_d;
   logic                    arready_q, arready_d;
   logic                    rvalid_q, rvalid_d;
   logic                    rlast_q, rlast_d;
   logic [AWID_WIDTH-1:0]   rid_q, rid_d;
   logic [WDATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;
   cmd_t                    cur_q, cur_d;
   logic [7:0]              beat_q, beat_d;

   logic                    ar_hs, r_adv, r_done, start, load;
   cmd_t                    ar_in, new_cmd, beat_cmd;
   logic [AWADDR_WIDTH-1:0] step, beat_addr, word;
   logic [MIDX_W-1:0]       midx;
   logic [WDATA_WIDTH-1:0]  rd_word;
   logic                    bad_cmd, oor;
   logic                    unused_c;

   assign unused_c = ^ARREGION;

   assign ar_in  = '{id: ARID, addr: ARADDR, len: ARLEN, size: ARSIZE, burst: ARBURST};
   assign ar_hs  = ARVALID & arready_q;
   assign r_adv  = rvalid_q & RREADY & ~rlast_q;
   assign r_done = rvalid_q & RREADY & rlast_q;
   assign load   = start | r_adv;

`ifdef AXI_RD_SLV_AR_QUEUE_EN
   cmd_t       fifo_head_c;
   logic       fifo_full, fifo_empty, fifo_push, fifo_pop, start_ok;
   logic [1:0] occ, occ_next;

   // An accepted AR bypasses the queue when nothing is waiting and a burst can start now.
   assign start_ok  = (state_q == ST_IDLE) | r_done;
   assign start     = start_ok & (~fifo_empty | ar_hs);
   assign new_cmd   = fifo_empty ? ar_in : fifo_head_c;
   assign fifo_pop  = start & ~fifo_empty;
   assign fifo_push = ar_hs & ~(start & fifo_empty);
   assign occ       = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
   assign occ_next  = occ + {1'b0, fifo_push} - {1'b0, fifo_pop};
   assign arready_d = (occ_next != 2'd2);

   axi_rd_ar_fifo #(.cmd_t(cmd_t)) u_ar_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (fifo_push),
      .pop    (fifo_pop),
      .din    (ar_in),
      .head_c (fifo_head_c),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );
`else
   assign start     = (state_q == ST_IDLE) & ar_hs;
   assign new_cmd   = ar_in;
   assign arready_d = (state_d == ST_IDLE);
`endif

   // Address and response of the beat presented at the coming edge.
   assign beat_cmd  = start ? new_cmd : cur_q;
   assign step      = (cur_q.burst == BURST_FIXED) ? '0 : (AWADDR_WIDTH'(1) << cur_q.size);
   assign beat_addr = start ? new_cmd.addr : (cur_q.addr + step);
   assign bad_cmd   = (beat_cmd.burst == BURST_WRAP) | (beat_cmd.burst == BURST_RSVD) |
                      (beat_cmd.size > 3'(BYTE_SHIFT));
   assign word      = beat_addr >> BYTE_SHIFT;
   assign oor       = (word >= AWADDR_WIDTH'(MEM_DEPTH));
   assign midx      = word[MIDX_W-1:0];
   assign rd_word   = (mem_we && (mem_waddr == midx)) ? mem_wdata : mem_q[midx];

   always_comb begin
      state_d  = state_q;
      rvalid_d = rvalid_q;
      rlast_d  = rlast_q;
      rid_d    = rid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      cur_d    = cur_q;
      beat_d   = beat_q;
      if (load) begin
         state_d    = ST_BURST;
         rvalid_d   = 1'b1;
         rid_d      = beat_cmd.id;
         cur_d      = beat_cmd;
         cur_d.addr = beat_addr;
         beat_d     = start ? 8'd0 : (beat_q + 8'd1);
         rlast_d    = (beat_d == beat_cmd.len);
         if (bad_cmd) begin
            rresp_d = RESP_SLVERR;
            rdata_d = '0;
         end else if (oor) begin
            rresp_d = RESP_DECERR;
            rdata_d = '0;
         end else begin
            rresp_d = RESP_OKAY;
            rdata_d = rd_word;
         end
      end else if (r_done) begin
         state_d  = ST_IDLE;
         rvalid_d = 1'b0;
         rlast_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         cur_q     <= '0;
         beat_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rid_q     <= rid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         cur_q     <= cur_d;
         beat_q    <= beat_d;
      end
   end

   // Memory contents survive reset; only the backdoor port writes them.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RLAST   = rlast_q;
   assign RID     = rid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_rd_slave.sv
// Directed self-checking bench for axi_rd_slave (default parameters).
// Expectations follow AXI_RD_SLV_AR_QUEUE_EN when the queue test runs.
module tb_axi_rd_slave;
   import axi_pkg::*;

   localparam int unsigned DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ARID;
   logic [31:0] ARADDR;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic [3:0]  ARREGION;
   logic        ARVALID;
   logic        ARREADY;
   logic [3:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY;
   logic        mem_we;
   logic [7:0]  mem_waddr;
   logic [31:0] mem_wdata;

   always #5 clk = ~clk;

   axi_rd_slave #(.MEM_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int n_got;
   int n_cyc;
   logic [31:0] bd [256];
   logic [3:0]  bi [256];
   logic [1:0]  br [256];
   logic        bl [256];

   task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bd_write(input int idx, input logic [31:0] v);
      mem_we    = 1'b1;
      mem_waddr = 8'(idx);
      mem_wdata = v;
      tick();
      mem_we    = 1'b0;
   endtask

   // Issue one AR; optionally backdoor-write the addressed word on the handshake edge.
   task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input bit bw, input logic [31:0] bwv);
      int w = 0;
      ARVALID = 1'b1;
      ARID    = id;
      ARADDR  = addr;
      ARLEN   = len;
      ARSIZE  = size;
      ARBURST = burst;
      while (!ARREADY && w < 50) begin
         tick();
         w++;
      end
      expect_eq("ar_ready_wait", ARREADY, 1);
      if (bw) begin
         mem_we    = 1'b1;
         mem_waddr = 8'(addr >> 2);
         mem_wdata = bwv;
      end
      tick();
      ARVALID = 1'b0;
      mem_we  = 1'b0;
      expect_eq("first_beat_latency", RVALID, 1);
   endtask

   // Collect n beats; with toggle, RREADY alternates and stalled beats must hold still.
   task automatic collect(input int n, input bit toggle);
      bit          rr   = 1'b1;
      bit          hold = 1'b0;
      logic [38:0] snap = '0;
      n_got = 0;
      n_cyc = 0;
      while (n_got < n && n_cyc < 600) begin
         if (hold) expect_eq("hold_stable", {RVALID, RID, RDATA, RRESP, RLAST}, {1'b1, snap});
         hold   = 1'b0;
         RREADY = rr;
         if (RVALID) begin
            if (rr) begin
               bd[n_got] = RDATA;
               bi[n_got] = RID;
               br[n_got] = RRESP;
               bl[n_got] = RLAST;
               n_got++;
            end else begin
               snap = {RID, RDATA, RRESP, RLAST};
               hold = 1'b1;
            end
         end
         tick();
         n_cyc++;
         if (toggle) rr = ~rr;
      end
      RREADY = 1'b0;
      expect_eq("beat_count", n_got, n);
   endtask

   task automatic expect_beat(input string tag, input int i, input logic [3:0] id,
                              input logic [31:0] d, input logic [1:0] r, input logic l);
      expect_eq($sformatf("%s[%0d]", tag, i), {bi[i], bd[i], br[i], bl[i]}, {id, d, r, l});
   endtask

   initial begin
      logic [31:0] exp_d;
      int          nl;
      int          nd;
      rst = 1'b0; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0;
      ARBURST = '0; ARREGION = 4'hF; RREADY = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;

      // Reset values, then ARREADY one edge after release
      #2 rst = 1'b1;
      #2;
      expect_eq("rst_arready", ARREADY, 0);
      expect_eq("rst_rvalid", RVALID, 0);
      expect_eq("rst_rlast", RLAST, 0);
      expect_eq("rst_rid", RID, 0);
      expect_eq("rst_rdata", RDATA, 0);
      expect_eq("rst_rresp", RRESP, 0);
      tick();
      tick();
      rst = 1'b0;
      expect_eq("arready_before_edge", ARREADY, 0);
      tick();
      expect_eq("arready_after_release", ARREADY, 1);

      for (int i = 0; i < 4; i++) bd_write(i, 32'hA0 + 32'(i));
      bd_write(DEPTH - 1, 32'hEE);

      // INCR len=3 full size, back-to-back
      RREADY = 1'b1;
      send_ar(4'd5, 32'h0, 8'd3, 3'd2, BURST_INCR, 1'b0, '0);
      collect(4, 1'b0);
      expect_eq("incr_cycles", n_cyc, 4);
      for (int i = 0; i < 4; i++) expect_beat("incr", i, 4'd5, 32'hA0 + 32'(i), RESP_OKAY, i == 3);
      expect_eq("incr_rvalid_drop", RVALID, 0);

      // Same burst with RREADY toggling
      send_ar(4'd5, 32'h0, 8'd3, 3'd2, BURST_INCR, 1'b0, '0);
      collect(4, 1'b1);
      for (int i = 0; i < 4; i++) expect_beat("toggle", i, 4'd5, 32'hA0 + 32'(i), RESP_OKAY, i == 3);
      expect_eq("toggle_rvalid_drop", RVALID, 0);

      // FIXED len=2 at word 2
      send_ar(4'd3, 32'h8, 8'd2, 3'd2, BURST_FIXED, 1'b0, '0);
      collect(3, 1'b0);
      for (int i = 0; i < 3; i++) expect_beat("fixed", i, 4'd3, 32'hA2, RESP_OKAY, i == 2);

      // WRAP len=1: slave error, zero data, count honoured
      send_ar(4'd7, 32'h4, 8'd1, 3'd2, BURST_WRAP, 1'b0, '0);
      collect(2, 1'b0);
      for (int i = 0; i < 2; i++) expect_beat("wrap", i, 4'd7, 32'h0, RESP_SLVERR, i == 1);

      // Oversized ARSIZE
      send_ar(4'd8, 32'h0, 8'd0, 3'd3, BURST_INCR, 1'b0, '0);
      collect(1, 1'b0);
      expect_beat("bigsize", 0, 4'd8, 32'h0, RESP_SLVERR, 1'b1);

      // Last word then beyond the memory
      send_ar(4'd9, 32'h3FC, 8'd1, 3'd2, BURST_INCR, 1'b0, '0);
      collect(2, 1'b0);
      expect_beat("decerr", 0, 4'd9, 32'hEE, RESP_OKAY, 1'b0);
      expect_beat("decerr", 1, 4'd9, 32'h0, RESP_DECERR, 1'b1);

      // Address wraps past 2^32 back to word 0
      send_ar(4'd10, 32'hFFFF_FFFC, 8'd1, 3'd2, BURST_INCR, 1'b0, '0);
      collect(2, 1'b0);
      expect_beat("addr_wrap", 0, 4'd10, 32'h0, RESP_DECERR, 1'b0);
      expect_beat("addr_wrap", 1, 4'd10, 32'hA0, RESP_OKAY, 1'b1);

      // Byte-size INCR: four beats in word 0, fifth in word 1, no lane shift
      send_ar(4'd11, 32'h0, 8'd4, 3'd0, BURST_INCR, 1'b0, '0);
      collect(5, 1'b0);
      for (int i = 0; i < 5; i++) expect_beat("narrow", i, 4'd11, (i == 4) ? 32'hA1 : 32'hA0, RESP_OKAY, i == 4);

      // Backdoor write on the read edge returns the new word
      send_ar(4'd12, 32'hC, 8'd0, 3'd2, BURST_FIXED, 1'b1, 32'h55);
      expect_eq("bypass_rdata", RDATA, 32'h55);
      collect(1, 1'b0);
      bd_write(3, 32'hA3);

      // ARLEN=255 gives 256 beats, single RLAST at the end
      send_ar(4'd13, 32'h0, 8'd255, 3'd2, BURST_FIXED, 1'b0, '0);
      collect(256, 1'b0);
      nl = 0;
      nd = 0;
      for (int i = 0; i < 256; i++) begin
         if (bl[i]) nl++;
         exp_d = 32'hA0;
         if (bd[i] !== exp_d) nd++;
      end
      expect_eq("len255_rlast_count", nl, 1);
      expect_eq("len255_rlast_final", bl[255], 1);
      expect_eq("len255_bad_data", nd, 0);

      // Reset during beat 2 of a len=7 burst
      send_ar(4'd4, 32'h0, 8'd7, 3'd2, BURST_INCR, 1'b0, '0);
      collect(2, 1'b0);
      expect_eq("pre_rst_beat2_valid", RVALID, 1);
      RREADY = 1'b1;
      #2 rst = 1'b1;
      #1;
      expect_eq("midrst_rvalid", RVALID, 0);
      expect_eq("midrst_rdata", RDATA, 0);
      expect_eq("midrst_arready", ARREADY, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      expect_eq("post_rst_rvalid", RVALID, 0);
      expect_eq("post_rst_arready", ARREADY, 1);
      tick();
      expect_eq("post_rst_no_beats", RVALID, 0);
      send_ar(4'd1, 32'h4, 8'd0, 3'd2, BURST_INCR, 1'b0, '0);
      collect(1, 1'b0);
      expect_beat("post_rst", 0, 4'd1, 32'hA1, RESP_OKAY, 1'b1);

      // Two ARs offered back to back
      RREADY  = 1'b1;
      ARVALID = 1'b1; ARID = 4'd1; ARADDR = 32'h0; ARLEN = 8'd1; ARSIZE = 3'd2; ARBURST = BURST_INCR;
      tick();
      expect_eq("q_b0", {RVALID, RID, RDATA, RLAST}, {1'b1, 4'd1, 32'hA0, 1'b0});
      ARID = 4'd2; ARADDR = 32'h8; ARLEN = 8'd0;
`ifdef AXI_RD_SLV_AR_QUEUE_EN
      expect_eq("q_arready_busy", ARREADY, 1);
      tick();
      ARVALID = 1'b0;
      expect_eq("q_b1", {RVALID, RID, RDATA, RLAST}, {1'b1, 4'd1, 32'hA1, 1'b1});
      tick();
      expect_eq("q_b2", {RVALID, RID, RDATA, RLAST}, {1'b1, 4'd2, 32'hA2, 1'b1});
      tick();
      expect_eq("q_done", RVALID, 0);
`else
      expect_eq("q_arready_busy", ARREADY, 0);
      tick();
      expect_eq("q_b1", {RVALID, RID, RDATA, RLAST}, {1'b1, 4'd1, 32'hA1, 1'b1});
      expect_eq("q_arready_b1", ARREADY, 0);
      tick();
      expect_eq("q_gap", {RVALID, ARREADY}, {1'b0, 1'b1});
      tick();
      ARVALID = 1'b0;
      expect_eq("q_b2", {RVALID, RID, RDATA, RLAST}, {1'b1, 4'd2, 32'hA2, 1'b1});
      tick();
      expect_eq("q_done", RVALID, 0);
`endif
      RREADY = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
